// File: rtl/uart_tx_scheduler.sv
// Store-bus UART transmit scheduler: decodes stores to the TX address, queues bytes
// in a small FIFO and launches one uart_tx transfer per byte while the serialiser is idle.
//
// state | meaning
// IDLE  | waiting for a queued byte and an idle serialiser; pops head byte on launch
// START | uart_tx_en pulse cycle
// HOLD  | skips uart_tx_busy while the serialiser's busy flag catches up
// WAIT  | waits for uart_tx_busy to fall
module uart_tx_scheduler #(
    parameter logic [31:0] TX_ADDR    = 32'h10000100,
    parameter logic [31:0] CLR_ADDR   = 32'h10000104,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           data_in,
    input  logic                  store_addr_in,
    input  logic                  store_data_in,
    input  logic                  uart_tx_busy,
    output logic                  uart_tx_en,
    output logic [7:0]            uart_tx_data,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        HOLD  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               sel_tx;
    logic               sel_clr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [7:0]         mem [DEPTH];
    logic               push;
    logic               push_ok;
    logic               drop;
    logic               pop;
    logic               clr;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_CNT);

    assign push    = store_data_in && sel_tx;
    assign clr     = store_data_in && sel_clr;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!fifo_full || pop);
    assign drop    = push && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_tx  <= 1'b0;
            sel_clr <= 1'b0;
        end else if (store_addr_in) begin
            sel_tx  <= (data_in == TX_ADDR);
            sel_clr <= (data_in == CLR_ADDR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage is deliberately left unreset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= 8'h00;
        end else begin
            state_q    <= state_d;
            uart_tx_en <= pop;
            if (pop) begin
                uart_tx_data <= mem[rd_ptr];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !uart_tx_busy) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: state_d = HOLD;
            HOLD:  state_d = WAIT;
            WAIT: begin
                if (!uart_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple serialiser busy model.
module tb_uart_tx_scheduler;

    localparam logic [31:0] TX_A  = 32'h10000100;
    localparam logic [31:0] CLR_A = 32'h10000104;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic        store_addr_in = 1'b0;
    logic        store_data_in = 1'b0;
    logic        uart_tx_busy;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic [3:0]  fifo_count;
    logic        fifo_empty;
    logic        fifo_full;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_len = 3;
    logic hold_busy = 1'b0;
    int busy_cnt = 0;
    logic prev_en = 1'b0;
    logic double_en = 1'b0;
    logic [7:0] launched[$];
    int launch_cyc[$];

    uart_tx_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .store_addr_in (store_addr_in),
        .store_data_in (store_data_in),
        .uart_tx_busy  (uart_tx_busy),
        .uart_tx_en    (uart_tx_en),
        .uart_tx_data  (uart_tx_data),
        .fifo_count    (fifo_count),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serialiser model: busy rises the cycle after uart_tx_en, lasts busy_len cycles.
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (uart_tx_en) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_tx_busy = (busy_cnt != 0) || hold_busy;

    always @(negedge clk) begin
        if (uart_tx_en) begin
            launched.push_back(uart_tx_data);
            launch_cyc.push_back(cyc);
        end
        if (uart_tx_en && prev_en) double_en <= 1'b1;
        prev_en <= uart_tx_en;
    end

    task automatic addr_beat(input logic [31:0] a);
        store_addr_in = 1'b1; data_in = a;
        @(negedge clk);
        store_addr_in = 1'b0; data_in = '0;
    endtask

    task automatic data_beat(input logic [7:0] d);
        store_data_in = 1'b1; data_in = {24'h0, d};
        @(negedge clk);
        store_data_in = 1'b0; data_in = '0;
    endtask

    task automatic wait_drain(input int base, input int n, input int budget);
        int k = 0;
        while ((launched.size() - base < n || !fifo_empty || uart_tx_busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL drain_timeout: launches %0d required %0d", launched.size() - base, n);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", uart_tx_en); end
        checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", uart_tx_data); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errors++; $display("FAIL reset_flags: empty %b full %b want 1 0", fifo_empty, fifo_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int base = launched.size();
        busy_len = 3;
        addr_beat(TX_A);
        data_beat(8'h41);
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
        checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL single_en_early: got %b want 0", uart_tx_en); end
        @(negedge clk);
        checks++; if (uart_tx_en !== 1'b1) begin errors++; $display("FAIL single_en: got %b want 1", uart_tx_en); end
        checks++; if (uart_tx_data !== 8'h41) begin errors++; $display("FAIL single_data: got %h want 41", uart_tx_data); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", fifo_count); end
        @(negedge clk);
        checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL single_en_pulse: got %b want 0", uart_tx_en); end
        wait_drain(base, 1, 50);
        checks++; if (launched.size() - base != 1) begin errors++; $display("FAIL single_launches: got %0d want 1", launched.size() - base); end
    endtask

    task automatic test_burst();
        int base = launched.size();
        busy_len = 20;
        hold_busy = 1'b1;
        addr_beat(TX_A);
        for (int i = 1; i <= 8; i++) data_beat(8'(i));
        checks++; if (fifo_full !== 1'b1 || fifo_count !== 4'd8) begin errors++; $display("FAIL burst_full: full %b count %0d want 1 8", fifo_full, fifo_count); end
        hold_busy = 1'b0;
        wait_drain(base, 8, 400);
        checks++; if (launched.size() - base != 8) begin errors++; $display("FAIL burst_launches: got %0d want 8", launched.size() - base); end
        for (int i = 0; i < 8 && base + i < launched.size(); i++) begin
            checks++; if (launched[base + i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_order[%0d]: got %h want %h", i, launched[base + i], 8'(i + 1)); end
        end
        for (int i = 1; i < 8 && base + i < launch_cyc.size(); i++) begin
            checks++; if (launch_cyc[base + i] - launch_cyc[base + i - 1] < 22) begin errors++; $display("FAIL burst_spacing[%0d]: got %0d want >=22", i, launch_cyc[base + i] - launch_cyc[base + i - 1]); end
        end
        checks++; if (fifo_empty !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL burst_end: empty %b ovf %b want 1 0", fifo_empty, overflow); end
    endtask

    task automatic test_overflow();
        int base = launched.size();
        busy_len = 20;
        hold_busy = 1'b1;
        addr_beat(TX_A);
        for (int i = 0; i < 8; i++) data_beat(8'h11 + 8'(i));
        checks++; if (fifo_count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: count %0d ovf %b want 8 0", fifo_count, overflow); end
        data_beat(8'h19);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", fifo_count); end
        addr_beat(CLR_A);
        data_beat(8'h00);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_clr_count: got %0d want 8", fifo_count); end
        hold_busy = 1'b0;
        wait_drain(base, 8, 400);
        repeat (30) @(negedge clk);
        checks++; if (launched.size() - base != 8) begin errors++; $display("FAIL ovf_launches: got %0d want 8", launched.size() - base); end
        for (int i = 0; i < 8 && base + i < launched.size(); i++) begin
            checks++; if (launched[base + i] !== 8'h11 + 8'(i)) begin errors++; $display("FAIL ovf_order[%0d]: got %h want %h", i, launched[base + i], 8'h11 + 8'(i)); end
        end
    endtask

    task automatic test_full_pop();
        int base = launched.size();
        busy_len = 4;
        hold_busy = 1'b1;
        addr_beat(TX_A);
        for (int i = 0; i < 8; i++) data_beat(8'h21 + 8'(i));
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fp_full: got %b want 1", fifo_full); end
        hold_busy = 1'b0;
        data_beat(8'h29);
        checks++; if (fifo_count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL fp_pushpop: count %0d ovf %b want 8 0", fifo_count, overflow); end
        checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h21) begin errors++; $display("FAIL fp_launch: en %b data %h want 1 21", uart_tx_en, uart_tx_data); end
        for (int i = 0; i < 11; i++) begin
            int k = 0;
            while (fifo_count >= 4'd8 && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (k >= 100) begin
                checks++; errors++;
                $display("FAIL fp_space_timeout: count %0d want <8", fifo_count);
            end
            data_beat(8'h2A + 8'(i));
        end
        wait_drain(base, 20, 400);
        checks++; if (launched.size() - base != 20) begin errors++; $display("FAIL fp_launches: got %0d want 20", launched.size() - base); end
        for (int i = 0; i < 20 && base + i < launched.size(); i++) begin
            checks++; if (launched[base + i] !== 8'h21 + 8'(i)) begin errors++; $display("FAIL fp_order[%0d]: got %h want %h", i, launched[base + i], 8'h21 + 8'(i)); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_decode();
        int base = launched.size();
        busy_len = 3;
        addr_beat(32'h10000000);
        data_beat(8'h55);
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL dec_ignore: count %0d want 0", fifo_count); end
        addr_beat(TX_A);
        data_beat(8'h66);
        data_beat(8'h66);
        wait_drain(base, 2, 100);
        repeat (10) @(negedge clk);
        checks++; if (launched.size() - base != 2) begin errors++; $display("FAIL dec_launches: got %0d want 2", launched.size() - base); end
        for (int i = 0; i < 2 && base + i < launched.size(); i++) begin
            checks++; if (launched[base + i] !== 8'h66) begin errors++; $display("FAIL dec_data[%0d]: got %h want 66", i, launched[base + i]); end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (uart_tx_en !== 1'b0 || uart_tx_data !== 8'h00 || fifo_count !== 4'd0 ||
            fifo_empty !== 1'b1 || fifo_full !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s: en %b data %h count %0d empty %b full %b ovf %b want 0 00 0 1 0 0",
                     tag, uart_tx_en, uart_tx_data, fifo_count, fifo_empty, fifo_full, overflow);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        busy_len = 20;
        hold_busy = 1'b1;
        addr_beat(TX_A);
        for (int i = 0; i < 3; i++) data_beat(8'h71 + 8'(i));
        checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL rm_count3: got %0d want 3", fifo_count); end
        hold_busy = 1'b0;
        @(negedge clk);
        checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h71) begin errors++; $display("FAIL rm_start: en %b data %h want 1 71", uart_tx_en, uart_tx_data); end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rm_start_reset");
        rst = 1'b0;
        base = launched.size();
        repeat (30) @(negedge clk);
        checks++; if (launched.size() != base) begin errors++; $display("FAIL rm_start_quiet: launches %0d want 0", launched.size() - base); end
        data_beat(8'h99);
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rm_sel_cleared: count %0d want 0", fifo_count); end

        hold_busy = 1'b1;
        addr_beat(TX_A);
        for (int i = 0; i < 4; i++) data_beat(8'h81 + 8'(i));
        hold_busy = 1'b0;
        @(negedge clk);
        checks++; if (uart_tx_en !== 1'b1 || fifo_count !== 4'd3) begin errors++; $display("FAIL rm_launch2: en %b count %0d want 1 3", uart_tx_en, fifo_count); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rm_wait_reset");
        rst = 1'b0;
        base = launched.size();
        repeat (40) @(negedge clk);
        checks++; if (launched.size() != base) begin errors++; $display("FAIL rm_wait_quiet: launches %0d want 0", launched.size() - base); end
        busy_len = 3;
        addr_beat(TX_A);
        data_beat(8'h7A);
        wait_drain(base, 1, 50);
        checks++; if (launched.size() - base != 1 || (launched.size() > base && launched[base] !== 8'h7A)) begin
            errors++; $display("FAIL rm_new_push: launches %0d want 1 of 7a", launched.size() - base);
        end
        checks++; if (double_en !== 1'b0) begin errors++; $display("FAIL en_consecutive: got %b want 0", double_en); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop();
        test_decode();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
